state_sequencer: RTL and testbench
==================================

# state_sequencer

Programmable brain-state playback engine that drives the state-request side of the configuration controller. It holds a small table of (state, transition duration, hold time) steps and issues them in order on `state_select` / `transition_duration`. It uses the controller's `transitioning` / `transition_to` status to know when each ramp has landed, then counts the hold interval before issuing the next step. It sits between host/top-level control and the configuration controller, and runs on the same 4 kHz `clk_en` tick.

## Interface
Parameters:
- `DEPTH`, 8: number of table entries (power of two).
- `ADDR_W`, 3: log2(DEPTH).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `clk_en`  in  1  4 kHz update tick; all sequencing advances only when high.
- `prog_we`  in  1  table write strobe; acts on any `clk` edge, not gated by `clk_en`.
- `prog_addr`  in  ADDR_W  entry to write.
- `prog_state`  in  3  target state code (0 NORMAL … 4 MEDITATION).
- `prog_tdur`  in  16  transition duration for the entry, in ticks.
- `prog_hold`  in  16  hold time after the ramp lands, in ticks.
- `seq_len`  in  ADDR_W+1  number of active entries. 0 = empty; values above DEPTH are clamped to DEPTH.
- `loop_en`  in  1  on the last entry, wrap to entry 0 instead of finishing.
- `start`  in  1  begin playback at entry 0 (sampled on `clk_en`).
- `stop`  in  1  abort playback (sampled on `clk_en`).
- `transitioning`  in  1  status from the configuration controller.
- `transition_to`  in  3  target latched by the configuration controller.
- `state_select`  out  3  requested state.
- `transition_duration`  out  16  requested ramp length.
- `seq_busy`  out  1  high in any state other than IDLE.
- `seq_index`  out  ADDR_W  entry currently issued.
- `step_strobe`  out  1  one-`clk` pulse when an entry is issued.
- `seq_done`  out  1  one-`clk` pulse on normal completion.
- `seq_error`  out  1  sticky watchdog flag; cleared by an accepted `start`.

## Operation
- Table: DEPTH entries × 35 bits, held in registers. Reset clears every entry to {state 0, tdur 0, hold 0}. A write lands on the `clk` edge where `prog_we`=1. Writes while busy are allowed; they take effect the next time that entry is issued.
- FSM states: IDLE, LAND, HOLD. All transitions happen only on ticks where `clk_en`=1.
- **Issue action** (used by IDLE→LAND and HOLD→LAND):
  - `state_select` ← entry[idx].state.
  - `transition_duration` ← entry[idx].tdur.
  - `seq_index` ← idx.
  - hold counter ← entry[idx].hold.
  - watchdog ← 0.
  - `step_strobe` = 1 for that cycle.
- **IDLE**:
  - Accept `start` only if `stop`=0 and the effective seq_len ≥ 1.
  - On accept: clear `seq_error`, set idx=0, issue, go to LAND.
  - Otherwise stay in IDLE. `state_select` and `transition_duration` keep their last values.
- **LAND**:
  - When `transition_to`==`state_select` and `transitioning`=0, go to HOLD.
  - An entry whose state equals the current target therefore lands on the first tick after issue.
  - Otherwise the watchdog increments each tick. When watchdog > max(tdur,1)+8: set `seq_error`, go to IDLE.
- **HOLD**:
  - When the hold counter is 0, advance. Otherwise decrement it.
  - Advance when idx < len−1: idx+1, issue, go to LAND.
  - Advance on the last entry with `loop_en`=1: idx=0, issue, go to LAND.
  - Advance on the last entry with `loop_en`=0: pulse `seq_done`, go to IDLE.
- **Stop and start priority**:
  - `stop`=1 on a tick forces IDLE from any state. It produces no `seq_done` and no issue, and leaves the outputs unchanged.
  - `start` and `stop` on the same tick: `stop` wins.
  - `start` while busy is ignored.
- `seq_len` and `loop_en` are sampled live, on every HOLD advance.
- Counters: the hold counter is 16 bits and cannot wrap, because it is only decremented when nonzero. The watchdog is 18 bits and saturates.

## Timing
- **Reset values**:
  - `state_select`=0, `transition_duration`=0, `seq_index`=0.
  - `seq_busy`=0, `step_strobe`=0, `seq_done`=0, `seq_error`=0.
  - FSM in IDLE, counters 0.
- **Reset mid-playback**: returns to the reset values immediately (asynchronous); no pulses are emitted.
- **Start latency**: `start` on tick T produces the issue on the `clk` edge of tick T. `step_strobe` and the new `state_select` are visible after that edge.
- **Controller handshake**: the controller latches `transition_to` at tick T+1, so the earliest LAND exit is tick T+2 for a state change and T+1 for a same-state entry.
- **Hold timing**: a hold of H spends exactly H+1 ticks in HOLD. The next issue occurs on the tick the counter is seen at 0.
- **Step period**: an entry with tdur=D≥1, hold=H and a differing state spans D+H+4 ticks from issue to next issue.
- **Pulse width**: `step_strobe` and `seq_done` are exactly one `clk` cycle wide and coincide with a `clk_en` tick.

## Test plan
- Reset, then write entries {PSYCHEDELIC, tdur 10, hold 5}, {NORMAL, 0, 0}; seq_len=2, loop_en=0; pulse `start` -> `state_select`=2 with a strobe, then 19 ticks later `state_select`=0, then `seq_done` 1 tick after landing, `seq_busy`=0.
- Single entry {NORMAL, tdur 50, hold 3} issued while the controller already targets NORMAL -> LAND exits 1 tick after issue; `seq_done` 5 ticks after issue.
- loop_en=1, seq_len=3 -> `seq_index` cycles 0,1,2,0,1; `seq_done` never pulses; `stop` mid-HOLD -> IDLE next tick, outputs hold their last values.
- Controller stubbed so `transitioning` sticks at 1 with tdur=20 -> `seq_error`=1 after 29 LAND ticks, FSM in IDLE; the next `start` clears `seq_error`.
- seq_len=0 with `start` -> no strobe, stays idle; seq_len=12 with DEPTH=8 -> plays 8 entries; `start`+`stop` on the same tick -> stays idle.
- Assert `rst` during LAND -> all outputs return to their reset values immediately; overwrite entry 1 while entry 0 holds -> the new values are issued.

Source files
------------

// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - Programmable state playback engine driving the configuration controller request port.
module state_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [2:0]        prog_state,
    input  logic [15:0]       prog_tdur,
    input  logic [15:0]       prog_hold,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              transitioning,
    input  logic [2:0]        transition_to,
    output logic [2:0]        state_select,
    output logic [15:0]       transition_duration,
    output logic              seq_busy,
    output logic [ADDR_W-1:0] seq_index,
    output logic              step_strobe,
    output logic              seq_done,
    output logic              seq_error
);
    typedef enum logic [1:0] {S_IDLE, S_LAND, S_HOLD} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    state_t            fsm;
    logic [15:0]       hold_cnt;
    logic [17:0]       watchdog;

    logic [2:0]        tbl_state [DEPTH];
    logic [15:0]       tbl_tdur  [DEPTH];
    logic [15:0]       tbl_hold  [DEPTH];

    logic [ADDR_W:0]   eff_len;
    logic              is_last;
    logic              landed;
    logic [17:0]       wd_inc;
    logic [17:0]       wd_limit;
    logic [ADDR_W-1:0] issue_idx;
    logic              do_issue;

    // Program port is independent of the tick so the host can load at full clock rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_state[i] <= '0;
                tbl_tdur[i]  <= '0;
                tbl_hold[i]  <= '0;
            end
        end else if (prog_we) begin
            tbl_state[prog_addr] <= prog_state;
            tbl_tdur[prog_addr]  <= prog_tdur;
            tbl_hold[prog_addr]  <= prog_hold;
        end
    end

    assign eff_len  = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
    assign is_last  = ({1'b0, seq_index} + (ADDR_W+1)'(1)) >= eff_len;
    assign landed   = !transitioning && (transition_to == state_select);
    assign wd_inc   = (watchdog == '1) ? watchdog : watchdog + 18'd1;
    assign wd_limit = {2'b00, (transition_duration == 16'd0) ? 16'd1 : transition_duration} + 18'd8;

    always_comb begin
        do_issue  = 1'b0;
        issue_idx = '0;
        if (clk_en && !stop) begin
            case (fsm)
                S_IDLE: do_issue = start && (eff_len != '0);
                S_HOLD: begin
                    do_issue = (hold_cnt == 16'd0) && (!is_last || loop_en);
                    if (!is_last) begin
                        issue_idx = seq_index + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm                 <= S_IDLE;
            state_select        <= '0;
            transition_duration <= '0;
            seq_index           <= '0;
            seq_busy            <= 1'b0;
            step_strobe         <= 1'b0;
            seq_done            <= 1'b0;
            seq_error           <= 1'b0;
            hold_cnt            <= '0;
            watchdog            <= '0;
        end else begin
            step_strobe <= 1'b0;
            seq_done    <= 1'b0;
            if (clk_en) begin
                if (stop) begin
                    fsm      <= S_IDLE;
                    seq_busy <= 1'b0;
                end else begin
                    case (fsm)
                        S_IDLE: ;
                        S_LAND: begin
                            if (landed) begin
                                fsm <= S_HOLD;
                            end else if (wd_inc > wd_limit) begin
                                seq_error <= 1'b1;
                                fsm       <= S_IDLE;
                                seq_busy  <= 1'b0;
                            end else begin
                                watchdog <= wd_inc;
                            end
                        end
                        S_HOLD: begin
                            if (hold_cnt != 16'd0) begin
                                hold_cnt <= hold_cnt - 16'd1;
                            end else if (is_last && !loop_en) begin
                                seq_done <= 1'b1;
                                fsm      <= S_IDLE;
                                seq_busy <= 1'b0;
                            end
                        end
                        default: fsm <= S_IDLE;
                    endcase
                    // Issue overrides whatever the case above scheduled for this tick.
                    if (do_issue) begin
                        if (fsm == S_IDLE) begin
                            seq_error <= 1'b0;
                        end
                        fsm                 <= S_LAND;
                        seq_busy            <= 1'b1;
                        state_select        <= tbl_state[issue_idx];
                        transition_duration <= tbl_tdur[issue_idx];
                        seq_index           <= issue_idx;
                        hold_cnt            <= tbl_hold[issue_idx];
                        watchdog            <= '0;
                        step_strobe         <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_state_sequencer.sv
// tb/tb_state_sequencer.sv - Self-checking bench for state_sequencer.
module tb_state_sequencer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_en = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [2:0]        prog_state = '0;
    logic [15:0]       prog_tdur = '0;
    logic [15:0]       prog_hold = '0;
    logic [ADDR_W:0]   seq_len = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              transitioning = 1'b0;
    logic [2:0]        transition_to = '0;
    logic [2:0]        state_select;
    logic [15:0]       transition_duration;
    logic              seq_busy;
    logic [ADDR_W-1:0] seq_index;
    logic              step_strobe;
    logic              seq_done;
    logic              seq_error;

    state_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_state(prog_state), .prog_tdur(prog_tdur), .prog_hold(prog_hold),
        .seq_len(seq_len), .loop_en(loop_en), .start(start), .stop(stop),
        .transitioning(transitioning), .transition_to(transition_to),
        .state_select(state_select), .transition_duration(transition_duration),
        .seq_busy(seq_busy), .seq_index(seq_index), .step_strobe(step_strobe),
        .seq_done(seq_done), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int tnow = 0;
    int strobe_count = 0;
    bit any_done = 0;
    bit p_strobe, p_done, p_err;
    bit ctl_stuck = 0;
    int ctl_cnt = 0;

    // Reference model: table, issue/land/deadline bookkeeping in tick numbers.
    logic [2:0]  m_st [DEPTH];
    logic [15:0] m_td [DEPTH];
    logic [15:0] m_hd [DEPTH];
    bit          m_busy, m_landed, m_err, m_strobe, m_done;
    int          m_idx, m_issue_t, m_next_t, m_hold;
    logic [2:0]  m_ss;
    logic [15:0] m_tdr;

    typedef struct {
        logic [3:0] len;
        logic       st;
        logic       sp;
        logic       exp_busy;
        logic       exp_strobe;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (tick %0d)", name, got, exp, tnow);
    endtask

    task automatic m_issue(input int i, input int t);
        m_ss      = m_st[i];
        m_tdr     = m_td[i];
        m_idx     = i;
        m_hold    = int'(m_hd[i]);
        m_issue_t = t;
        m_landed  = 0;
        m_busy    = 1;
        m_strobe  = 1;
    endtask

    task automatic model_step(input int t);
        int len, lim;
        len = (int'(seq_len) > DEPTH) ? DEPTH : int'(seq_len);
        lim = ((m_tdr == 16'd0) ? 1 : int'(m_tdr)) + 8;
        m_strobe = 0;
        m_done   = 0;
        if (stop) m_busy = 0;
        else if (!m_busy) begin
            if (start && len >= 1) begin
                m_err = 0;
                m_issue(0, t);
            end
        end else if (!m_landed) begin
            if (transition_to == m_ss && !transitioning) begin
                m_landed = 1;
                m_next_t = t + m_hold + 1;
            end else if (t - m_issue_t > lim) begin
                m_err  = 1;
                m_busy = 0;
            end
        end else if (t == m_next_t) begin
            if (m_idx < len - 1) m_issue(m_idx + 1, t);
            else if (loop_en) m_issue(0, t);
            else begin
                m_done = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic tick();
        logic [2:0]  ss_pre;
        logic [15:0] td_pre;
        ss_pre = state_select;
        td_pre = transition_duration;
        model_step(tnow + 1);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        tnow++;
        p_strobe = step_strobe;
        p_done   = seq_done;
        p_err    = seq_error;
        if (p_done) any_done = 1;
        if (p_strobe) strobe_count++;
        chk("model", 32'({state_select, transition_duration, seq_index, seq_busy, step_strobe, seq_done, seq_error}),
            32'({m_ss, m_tdr, 3'(m_idx), m_busy, m_strobe, m_done, m_err}));
        // Configuration controller stub: latches a new target one tick after it appears.
        if (ctl_stuck) transitioning = 1'b1;
        else if (transitioning) begin
            if (ctl_cnt == 0) transitioning = 1'b0;
            else ctl_cnt--;
        end else if (ss_pre != transition_to) begin
            transition_to = ss_pre;
            transitioning = 1'b1;
            ctl_cnt       = int'(td_pre);
        end
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse_width", 32'({step_strobe, seq_done}), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_until(input int which, input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            n++;
            if ((which == 0 && p_strobe) || (which == 1 && p_done) || (which == 2 && p_err)) return;
        end
        n_total++;
        $display("FAIL wait_event%0d: got no event after %0d ticks required within budget", which, budget);
        n = -1;
    endtask

    task automatic prog(input int a, input logic [2:0] s, input logic [15:0] d, input logic [15:0] h);
        prog_we    = 1'b1;
        prog_addr  = 3'(a);
        prog_state = s;
        prog_tdur  = d;
        prog_hold  = h;
        @(negedge clk);
        prog_we = 1'b0;
        m_st[a] = s;
        m_td[a] = d;
        m_hd[a] = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_outputs", 32'({state_select, transition_duration, seq_index, seq_busy, step_strobe, seq_done, seq_error}), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = '0;
            m_td[i] = '0;
            m_hd[i] = '0;
        end
        m_busy = 0; m_landed = 0; m_err = 0; m_strobe = 0; m_done = 0;
        m_idx = 0; m_ss = '0; m_tdr = '0; m_hold = 0;
        transitioning = 1'b0; transition_to = '0; ctl_cnt = 0; ctl_stuck = 0;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit [14:0] iseq;
        int sc0;

        vecs[0] = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd12, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd1,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{4'd12, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{4'd8,  1'b0, 1'b1, 1'b0, 1'b0};

        // Two-entry playback
        do_reset();
        prog(0, 3'd2, 16'd10, 16'd5);
        prog(1, 3'd0, 16'd0, 16'd0);
        seq_len = 4'd2; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_first_issue", 32'({p_strobe, state_select, transition_duration, seq_index, seq_busy}),
            32'({1'b1, 3'd2, 16'd10, 3'd0, 1'b1}));
        run_until(0, 60, n);
        chk("t1_step_period", 32'(n), 32'd19);
        chk("t1_second_state", 32'({state_select, seq_index}), 32'({3'd0, 3'd1}));
        run_until(1, 20, n);
        chk("t1_done_latency", 32'(n), 32'd4);
        chk("t1_idle", 32'(seq_busy), 32'd0);

        // Same-state entry lands on the first tick
        do_reset();
        prog(0, 3'd0, 16'd50, 16'd3);
        seq_len = 4'd1;
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_issue", 32'({p_strobe, transition_duration}), 32'({1'b1, 16'd50}));
        run_until(1, 20, n);
        chk("t2_done_latency", 32'(n), 32'd5);

        // Looping and stop mid-HOLD
        do_reset();
        prog(0, 3'd1, 16'd2, 16'd1);
        prog(1, 3'd3, 16'd1, 16'd6);
        prog(2, 3'd4, 16'd3, 16'd0);
        seq_len = 4'd3; loop_en = 1'b1; any_done = 0;
        start = 1'b1; tick(); start = 1'b0;
        iseq = 15'(seq_index);
        for (int k = 0; k < 4; k++) begin
            run_until(0, 40, n);
            iseq = {iseq[11:0], seq_index};
        end
        chk("t3_index_seq", 32'(iseq), 32'({3'd0, 3'd1, 3'd2, 3'd0, 3'd1}));
        repeat (6) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t3_stop_idle", 32'({seq_busy, p_strobe, p_done}), 32'd0);
        chk("t3_stop_outputs", 32'({state_select, transition_duration, seq_index}), 32'({3'd3, 16'd1, 3'd1}));
        sc0 = strobe_count;
        repeat (15) tick();
        chk("t3_no_restart", 32'(strobe_count - sc0), 32'd0);
        chk("t3_no_done", 32'(any_done), 32'd0);

        // Watchdog with a stuck controller
        do_reset();
        prog(0, 3'd2, 16'd20, 16'd0);
        seq_len = 4'd1; loop_en = 1'b0; ctl_stuck = 1;
        start = 1'b1; tick(); start = 1'b0;
        run_until(2, 60, n);
        chk("t4_watchdog_ticks", 32'(n), 32'd29);
        chk("t4_idle", 32'(seq_busy), 32'd0);
        ctl_stuck = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_err_cleared", 32'({seq_error, p_strobe}), 32'({1'b0, 1'b1}));

        // Start acceptance vectors from IDLE
        do_reset();
        for (int i = 0; i < 6; i++) begin
            seq_len = vecs[i].len;
            start   = vecs[i].st;
            stop    = vecs[i].sp;
            tick();
            start = 1'b0;
            stop  = 1'b0;
            chk($sformatf("vec%0d", i), 32'({seq_busy, p_strobe}), 32'({vecs[i].exp_busy, vecs[i].exp_strobe}));
            stop = 1'b1; tick(); stop = 1'b0;
        end
        seq_len = 4'd12; loop_en = 1'b0;
        sc0 = strobe_count;
        start = 1'b1; tick(); start = 1'b0;
        run_until(1, 60, n);
        chk("t5_clamp_steps", 32'(strobe_count - sc0), 32'd8);
        chk("t5_clamp_last", 32'(seq_index), 32'd7);

        // Asynchronous reset during LAND, then rewrite during HOLD
        do_reset();
        prog(0, 3'd3, 16'd10, 16'd0);
        seq_len = 4'd1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("t6_busy_before_rst", 32'(seq_busy), 32'd1);
        do_reset();
        prog(0, 3'd1, 16'd1, 16'd8);
        prog(1, 3'd2, 16'd2, 16'd0);
        seq_len = 4'd2; loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        prog(1, 3'd4, 16'd7, 16'd0);
        run_until(0, 30, n);
        chk("t6_hold_timing", 32'(n), 32'd7);
        chk("t6_new_entry", 32'({state_select, transition_duration, seq_index}), 32'({3'd4, 16'd7, 3'd1}));

        // Randomized playback against the model
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            prog(a, 3'($urandom_range(0, 4)), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 4)));
        end
        seq_len = 4'd3; loop_en = 1'b1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) seq_len = 4'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 49) == 0)
                prog($urandom_range(0, DEPTH - 1), 3'($urandom_range(0, 4)), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 4)));
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
